// File: rtl/lc2k_program_loader.sv
// LC2K program loader: encodes symbolic instruction fields or raw fill words
// into 32-bit machine words and writes them to instruction memory at sequential addresses.
`timescale 1ns/1ps
module lc2k_program_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [ADDR_W-1:0] start_count,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_regA,
  input  logic [2:0]        in_regB,
  input  logic [2:0]        in_dest,
  input  logic [15:0]       in_offset,
  input  logic [31:0]       in_fill,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_wrap,
  output logic [ADDR_W-1:0] words_written
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              err_wrap_q, err_wrap_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              accept;
  logic [31:0]       enc_word;

  // Field layout must match what the control decoder expects on read-back.
  function automatic logic [31:0] encode(
    input logic        kind,
    input logic [2:0]  opcode,
    input logic [2:0]  rega,
    input logic [2:0]  regb,
    input logic [2:0]  dest,
    input logic [15:0] offset,
    input logic [31:0] fill
  );
    logic [31:0] w;
    w = '0;
    if (kind) begin
      w = fill;
    end else begin
      w[24:22] = opcode;
      case (opcode)
        OP_ADD, OP_NOR: begin
          w[21:19] = rega;
          w[18:16] = regb;
          w[2:0]   = dest;
        end
        OP_LW, OP_SW, OP_BEQ: begin
          w[21:19] = rega;
          w[18:16] = regb;
          w[15:0]  = offset;
        end
        OP_JALR: begin
          w[21:19] = rega;
          w[18:16] = regb;
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  assign enc_word = encode(in_kind, in_opcode, in_regA, in_regB, in_dest,
                           in_offset, in_fill);

  // Abort takes priority: an item presented alongside it is dropped.
  assign accept = (state_q == LOAD) && in_ready_q && in_valid && !abort;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    err_wrap_d  = err_wrap_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = accept;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_count != '0) begin
            state_d     = LOAD;
            ptr_d       = start_base;
            remaining_d = start_count;
            err_wrap_d  = 1'b0;
            words_d     = '0;
            in_ready_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d    = IDLE;
          in_ready_d = 1'b0;
        end else if (accept) begin
          mem_addr_d  = ptr_q;
          mem_wdata_d = enc_word;
          remaining_d = remaining_q - ONE;
          words_d     = words_q + ONE;
          if (ptr_q == LAST_ADDR) begin
            ptr_d      = '0;
            err_wrap_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ONE;
          end
          if (remaining_q == ONE) begin
            state_d    = DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      err_wrap_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      err_wrap_q  <= err_wrap_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = (state_q == LOAD);
  assign done          = done_q;
  assign err_wrap      = err_wrap_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_lc2k_program_loader.sv
// Directed testbench for lc2k_program_loader with hand-computed expected words.
`timescale 1ns/1ps
module tb_lc2k_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_base;
  logic [15:0] start_count;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [2:0]  in_opcode;
  logic [2:0]  in_regA;
  logic [2:0]  in_regB;
  logic [2:0]  in_dest;
  logic [15:0] in_offset;
  logic [31:0] in_fill;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err_wrap;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  lc2k_program_loader #(.ADDR_W(16), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_base(start_base),
    .start_count(start_count), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_opcode(in_opcode),
    .in_regA(in_regA), .in_regB(in_regB), .in_dest(in_dest),
    .in_offset(in_offset), .in_fill(in_fill), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_wrap(err_wrap), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] count);
    start       = 1'b1;
    start_base  = base;
    start_count = count;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input string tag, input logic kind, input logic [2:0] op,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                      input logic [15:0] off, input logic [31:0] fill,
                      input logic [15:0] exp_addr, input logic [31:0] exp_data);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_opcode = op;
    in_regA   = a;
    in_regB   = b;
    in_dest   = d;
    in_offset = off;
    in_fill   = fill;
    tick();
    in_valid = 1'b0;
    chk({tag, "_we"},   {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
    chk({tag, "_data"}, mem_wdata, exp_data);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_base = '0; start_count = '0; abort = 1'b0;
    in_valid = 1'b0; in_kind = 1'b0; in_opcode = '0; in_regA = '0; in_regB = '0;
    in_dest = '0; in_offset = '0; in_fill = '0;
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_wrap",  {31'd0, err_wrap}, 32'd0);
    chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
    chk("rst_data",  mem_wdata, 32'd0);
    chk("rst_words", {16'd0, words_written}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Field encoding
    pulse_start(16'd0, 16'd3);
    chk("t1_busy",  {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_we0",   {31'd0, mem_we}, 32'd0);
    send("t1_add", 1'b0, 3'b000, 3'd1, 3'd2, 3'd3, 16'h0000, 32'h0, 16'd0, 32'h000A0003);
    send("t1_lw",  1'b0, 3'b010, 3'd0, 3'd1, 3'd0, 16'h0005, 32'h0, 16'd1, 32'h00810005);
    send("t1_beq", 1'b0, 3'b100, 3'd1, 3'd1, 3'd0, 16'hFFFF, 32'h0, 16'd2, 32'h0109FFFF);
    chk("t1_done",   {31'd0, done}, 32'd1);
    chk("t1_busy_d", {31'd0, busy}, 32'd0);
    chk("t1_rdy_d",  {31'd0, in_ready}, 32'd0);
    tick();
    chk("t1_done_once", {31'd0, done}, 32'd0);
    chk("t1_we_off",    {31'd0, mem_we}, 32'd0);
    chk("t1_words",     {16'd0, words_written}, 32'd3);
    chk("t1_addr_hold", {16'd0, mem_addr}, 32'd2);

    // Don't-care fields; a start mid-load must not disturb the address sequence
    pulse_start(16'd3, 16'd3);
    send("t2_halt", 1'b0, 3'b110, 3'd7, 3'd7, 3'd7, 16'hFFFF, 32'hFFFFFFFF, 16'd3, 32'h01800000);
    start = 1'b1; start_base = 16'd100; start_count = 16'd100;
    send("t2_noop", 1'b0, 3'b111, 3'd5, 3'd3, 3'd6, 16'hABCD, 32'h12345678, 16'd4, 32'h01C00000);
    start = 1'b0;
    send("t2_jalr", 1'b0, 3'b101, 3'd4, 3'd2, 3'd7, 16'h1234, 32'h0, 16'd5, 32'h01620000);
    chk("t2_done", {31'd0, done}, 32'd1);
    tick();

    // Backpressure with a fill word
    pulse_start(16'd10, 16'd1);
    tick();
    chk("t3_idle1", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t3_idle2", {31'd0, mem_we}, 32'd0);
    chk("t3_ready", {31'd0, in_ready}, 32'd1);
    send("t3_fill", 1'b1, 3'b000, 3'd1, 3'd2, 3'd3, 16'h0, 32'hDEADBEEF, 16'd10, 32'hDEADBEEF);
    chk("t3_done", {31'd0, done}, 32'd1);
    tick();
    chk("t3_we_off", {31'd0, mem_we}, 32'd0);
    chk("t3_words",  {16'd0, words_written}, 32'd1);

    // Address wrap
    pulse_start(16'd255, 16'd2);
    send("t4_w0", 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 32'h11111111, 16'd255, 32'h11111111);
    chk("t4_wrap_set", {31'd0, err_wrap}, 32'd1);
    send("t4_w1", 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 32'h22222222, 16'd0, 32'h22222222);
    tick();
    tick();
    chk("t4_wrap_hold", {31'd0, err_wrap}, 32'd1);

    // Abort together with the second accept
    pulse_start(16'd20, 16'd4);
    chk("t5_wrap_clr", {31'd0, err_wrap}, 32'd0);
    send("t5_w0", 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 32'hA5A5A5A5, 16'd20, 32'hA5A5A5A5);
    in_valid = 1'b1; in_fill = 32'h5A5A5A5A; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("t5_no_we",  {31'd0, mem_we}, 32'd0);
    chk("t5_busy",   {31'd0, busy}, 32'd0);
    chk("t5_ready",  {31'd0, in_ready}, 32'd0);
    chk("t5_nodone", {31'd0, done}, 32'd0);
    chk("t5_words",  {16'd0, words_written}, 32'd1);
    tick();
    chk("t5_nodone2", {31'd0, done}, 32'd0);
    pulse_start(16'd30, 16'd1);
    chk("t5_restart", {31'd0, busy}, 32'd1);
    send("t5_w2", 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 32'hCAFEF00D, 16'd30, 32'hCAFEF00D);
    tick();

    // Zero-length load
    pulse_start(16'd40, 16'd0);
    chk("t6_done",  {31'd0, done}, 32'd1);
    chk("t6_busy",  {31'd0, busy}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t6_done_off", {31'd0, done}, 32'd0);

    // Reset mid-load
    pulse_start(16'd50, 16'd5);
    send("t7_w0", 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 32'h0BADC0DE, 16'd50, 32'h0BADC0DE);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t7_we",    {31'd0, mem_we}, 32'd0);
    chk("t7_ready", {31'd0, in_ready}, 32'd0);
    chk("t7_busy",  {31'd0, busy}, 32'd0);
    chk("t7_words", {16'd0, words_written}, 32'd0);
    chk("t7_data",  mem_wdata, 32'd0);
    #3;
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t7_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
